// File: rtl/emif_tg_pkg.sv
// Shared types, AXI constants and data-pattern helpers for the EMIF AXI traffic generator.
package emif_tg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AW,
    ST_W,
    ST_B,
    ST_AR,
    ST_R,
    ST_DONE
  } tg_state_e;

  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] BURST_INCR = 2'b01;

  // Right-shifting Galois form of x^32 + x^22 + x^2 + x + 1.
  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
  localparam logic [31:0] GOLDEN    = 32'h9E37_79B9;

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return {1'b0, s[31:1]} ^ (s[0] ? LFSR_POLY : 32'h0);
  endfunction

  function automatic logic [31:0] beat_word(input logic [31:0] s, input logic [31:0] idx);
    return s ^ (idx * GOLDEN);
  endfunction

endpackage

// File: rtl/emif_tg_lfsr.sv
// Seeded LFSR that expands its state into a full-width beat pattern.
module emif_tg_lfsr
  import emif_tg_pkg::*;
#(
  parameter int          DATA_W = 256,
  parameter logic [31:0] SEED   = 32'h1234_5678
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              advance,
  output logic [DATA_W-1:0] pattern
);

  logic [31:0] state;

  always_ff @(posedge clk) begin
    if (reset || load) begin
      state <= SEED;
    end else if (advance) begin
      state <= lfsr_next(state);
    end
  end

  always_comb begin
    pattern = '0;
    for (int i = 0; i < DATA_W / 32; i++) begin
      pattern[i*32 +: 32] = beat_word(state, 32'(i));
    end
  end

endmodule

// File: rtl/emif_axi_traffic_gen.sv
// AXI4 write-then-read-back traffic generator for the EMIF user port.
// Handshakes: a beat transfers on the rising edge where valid and ready are both high; payload holds while valid && !ready.
module emif_axi_traffic_gen
  import emif_tg_pkg::*;
#(
  parameter int                ADDR_W     = 33,
  parameter int                DATA_W     = 256,
  parameter int                ID_W       = 7,
  parameter int                BURST_LEN  = 4,
  parameter int                NUM_BURSTS = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
  parameter logic [31:0]       SEED       = 32'h1234_5678
) (
  input  logic                clk_clk,
  input  logic                reset_reset,
  input  logic                start,
  output logic [ADDR_W-1:0]   awaddr,
  output logic [7:0]          awlen,
  output logic [2:0]          awsize,
  output logic [1:0]          awburst,
  output logic [ID_W-1:0]     awid,
  output logic                awvalid,
  input  logic                awready,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wlast,
  output logic                wvalid,
  input  logic                wready,
  input  logic [1:0]          bresp,
  input  logic                bvalid,
  output logic                bready,
  output logic [ADDR_W-1:0]   araddr,
  output logic [7:0]          arlen,
  output logic [2:0]          arsize,
  output logic [1:0]          arburst,
  output logic [ID_W-1:0]     arid,
  output logic                arvalid,
  input  logic                arready,
  input  logic [DATA_W-1:0]   rdata,
  input  logic [1:0]          rresp,
  input  logic                rlast,
  input  logic                rvalid,
  output logic                rready,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic                fail,
  output logic [31:0]         err_count,
  output logic [ADDR_W-1:0]   first_err_addr,
  output tg_state_e           dbg_state
);

  localparam int                BEAT_BYTES  = DATA_W / 8;
  localparam int                SIZE        = $clog2(BEAT_BYTES);
  localparam logic [ADDR_W-1:0] BURST_BYTES = ADDR_W'(BEAT_BYTES * BURST_LEN);
  localparam logic [4:0]        LAST_BEAT   = 5'(BURST_LEN - 1);
  localparam int                BCNT_W      = (NUM_BURSTS > 1) ? $clog2(NUM_BURSTS) : 1;
  localparam logic [BCNT_W-1:0] LAST_BURST  = BCNT_W'(NUM_BURSTS - 1);

  tg_state_e         state;
  logic [4:0]        beat_cnt;
  logic [BCNT_W-1:0] burst_cnt;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wr_pattern, rd_pattern;
  logic              run_start, wr_adv, rd_load, rd_adv;
  logic              b_err, r_err, err_evt;
  logic [ADDR_W-1:0] beat_addr, err_addr;

  assign run_start = (state == ST_IDLE || state == ST_DONE) && start;
  assign wr_adv    = (state == ST_W) && wvalid && wready;
  assign rd_load   = run_start || ((state == ST_B) && bvalid && burst_cnt == LAST_BURST);
  assign rd_adv    = (state == ST_R) && rvalid;
  assign beat_addr = addr + (ADDR_W'(beat_cnt) << SIZE);

  // A beat with several faults still counts as a single error.
  always_comb begin
    b_err    = (state == ST_B) && bvalid && (bresp != RESP_OKAY);
    r_err    = (state == ST_R) && rvalid &&
               (rdata != rd_pattern || rresp != RESP_OKAY || (rlast && beat_cnt != LAST_BEAT));
    err_evt  = b_err || r_err;
    err_addr = b_err ? addr : beat_addr;
  end

  emif_tg_lfsr #(.DATA_W(DATA_W), .SEED(SEED)) u_wr_gen (
    .clk(clk_clk), .reset(reset_reset), .load(run_start), .advance(wr_adv), .pattern(wr_pattern)
  );

  emif_tg_lfsr #(.DATA_W(DATA_W), .SEED(SEED)) u_rd_chk (
    .clk(clk_clk), .reset(reset_reset), .load(rd_load), .advance(rd_adv), .pattern(rd_pattern)
  );

  assign awaddr    = addr;
  assign araddr    = addr;
  assign awlen     = 8'(BURST_LEN - 1);
  assign arlen     = 8'(BURST_LEN - 1);
  assign awsize    = 3'(SIZE);
  assign arsize    = 3'(SIZE);
  assign awburst   = BURST_INCR;
  assign arburst   = BURST_INCR;
  assign awid      = '0;
  assign arid      = '0;
  assign wdata     = wr_pattern;
  assign wstrb     = '1;
  assign wlast     = wvalid && (beat_cnt == LAST_BEAT);
  assign dbg_state = state;

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state          <= ST_IDLE;
      awvalid        <= 1'b0;
      wvalid         <= 1'b0;
      bready         <= 1'b0;
      arvalid        <= 1'b0;
      rready         <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      fail           <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
      addr           <= BASE_ADDR;
      beat_cnt       <= '0;
      burst_cnt      <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state          <= ST_AW;
            awvalid        <= 1'b1;
            busy           <= 1'b1;
            done           <= 1'b0;
            pass           <= 1'b0;
            fail           <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
            addr           <= BASE_ADDR;
            beat_cnt       <= '0;
            burst_cnt      <= '0;
          end
        end
        ST_AW: begin
          if (awready) begin
            awvalid  <= 1'b0;
            wvalid   <= 1'b1;
            beat_cnt <= '0;
            state    <= ST_W;
          end
        end
        ST_W: begin
          if (wready) begin
            if (beat_cnt == LAST_BEAT) begin
              wvalid <= 1'b0;
              bready <= 1'b1;
              state  <= ST_B;
            end else begin
              beat_cnt <= beat_cnt + 5'd1;
            end
          end
        end
        ST_B: begin
          if (bvalid) begin
            bready <= 1'b0;
            if (burst_cnt == LAST_BURST) begin
              addr      <= BASE_ADDR;
              burst_cnt <= '0;
              arvalid   <= 1'b1;
              state     <= ST_AR;
            end else begin
              addr      <= addr + BURST_BYTES;
              burst_cnt <= burst_cnt + BCNT_W'(1);
              awvalid   <= 1'b1;
              state     <= ST_AW;
            end
          end
        end
        ST_AR: begin
          if (arready) begin
            arvalid  <= 1'b0;
            rready   <= 1'b1;
            beat_cnt <= '0;
            state    <= ST_R;
          end
        end
        ST_R: begin
          if (rvalid) begin
            if (rlast) begin
              rready <= 1'b0;
              if (burst_cnt == LAST_BURST) begin
                busy  <= 1'b0;
                done  <= 1'b1;
                pass  <= (err_count == '0) && !err_evt;
                fail  <= (err_count != '0) || err_evt;
                state <= ST_DONE;
              end else begin
                addr      <= addr + BURST_BYTES;
                burst_cnt <= burst_cnt + BCNT_W'(1);
                arvalid   <= 1'b1;
                state     <= ST_AR;
              end
            end else begin
              beat_cnt <= beat_cnt + 5'd1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase

      if (err_evt) begin
        if (err_count == '0) first_err_addr <= err_addr;
        if (err_count != '1) err_count <= err_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_emif_axi_traffic_gen.sv
// Bench for emif_axi_traffic_gen: memory-backed AXI responder with fault injection and a spec-level model.
module tb_emif_axi_traffic_gen;
  import emif_tg_pkg::*;

  localparam int                ADDR_W = 33;
  localparam int                DATA_W = 256;
  localparam int                ID_W   = 7;
  localparam int                BL     = 4;
  localparam int                NB     = 8;
  localparam int                BEAT_B = DATA_W / 8;
  localparam logic [ADDR_W-1:0] BASE   = 33'h1_FFFF_FE00;
  localparam logic [31:0]       SEED   = 32'h1234_5678;

  logic                clk = 1'b0;
  logic                reset, start;
  logic [ADDR_W-1:0]   awaddr, araddr;
  logic [7:0]          awlen, arlen;
  logic [2:0]          awsize, arsize;
  logic [1:0]          awburst, arburst;
  logic [ID_W-1:0]     awid, arid;
  logic                awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic                arvalid, arready, rlast, rvalid, rready;
  logic [DATA_W-1:0]   wdata, rdata;
  logic [DATA_W/8-1:0] wstrb;
  logic [1:0]          bresp, rresp;
  logic                busy, done, pass, fail;
  logic [31:0]         err_count;
  logic [ADDR_W-1:0]   first_err_addr;
  tg_state_e           dbg_state;

  emif_axi_traffic_gen #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .BURST_LEN(BL),
    .NUM_BURSTS(NB), .BASE_ADDR(BASE), .SEED(SEED)
  ) dut (
    .clk_clk(clk), .reset_reset(reset), .start(start),
    .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst), .awid(awid),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst), .arid(arid),
    .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .busy(busy), .done(done), .pass(pass), .fail(fail),
    .err_count(err_count), .first_err_addr(first_err_addr), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int tests_run = 0, tests_failed = 0;

  // Responder configuration and fault injection (-1 disables).
  bit rnd_mode = 1'b0;
  int flip_burst = -1, flip_beat = -1, bresp_burst = -1, rresp_burst = -1, rresp_beat = -1;

  // Responder and model state.
  int                aw_n, w_n, b_n, ar_n, r_n, w_beat, r_beat;
  int                stab_err, wdata_err, order_err, addr_err;
  bit                w_open, b_pend, r_act, b_hs, r_hs;
  bit                prev_awv, prev_aw_hs, prev_wv, prev_w_hs, prev_arv, prev_ar_hs;
  logic [ADDR_W-1:0] prev_awaddr, prev_araddr, w_base, r_base;
  logic [DATA_W-1:0] prev_wdata;
  logic              prev_wlast;
  logic [31:0]       m_lfsr;
  logic [ADDR_W-1:0] exp_q[$];
  logic [DATA_W-1:0] mem [logic [ADDR_W-1:0]];

  // x^32 + x^22 + x^2 + x + 1, shifting toward bit 0.
  function automatic logic [31:0] m_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
  endfunction

  function automatic logic [DATA_W-1:0] m_beat(input logic [31:0] s);
    logic [DATA_W-1:0] d;
    logic [31:0]       k;
    for (int i = 0; i < DATA_W / 32; i++) begin
      k = i;
      d[i*32 +: 32] = s ^ (k * 32'h9E37_79B9);
    end
    return d;
  endfunction

  function automatic logic [ADDR_W-1:0] burst_addr(input int n);
    return BASE + ADDR_W'(n * BL * BEAT_B);
  endfunction

  // Inputs change only on the falling edge; a handshake seen here transfers on the next rising edge.
  always @(negedge clk) begin
    if (reset) begin
      awready = 0; wready = 0; bvalid = 0; bresp = 0; arready = 0;
      rvalid = 0; rdata = '0; rresp = 0; rlast = 0;
      w_open = 0; b_pend = 0; r_act = 0; b_hs = 0; r_hs = 0;
      prev_awv = 0; prev_aw_hs = 0; prev_wv = 0; prev_w_hs = 0; prev_arv = 0; prev_ar_hs = 0;
    end else begin
      if (b_hs) bvalid = 0;
      if (!bvalid && b_pend && (!rnd_mode || $urandom_range(0, 2) == 0)) begin
        bvalid = 1;
        bresp  = (b_n == bresp_burst) ? 2'b10 : 2'b00;
      end
      b_hs = bvalid && bready;
      if (b_hs) begin b_pend = 0; b_n++; end

      if (r_hs) rvalid = 0;
      if (!rvalid && r_act && (!rnd_mode || $urandom_range(0, 2) != 0)) begin
        rvalid = 1;
        rdata  = mem.exists(r_base + ADDR_W'(r_beat * BEAT_B)) ? mem[r_base + ADDR_W'(r_beat * BEAT_B)] : '0;
        if (ar_n - 1 == flip_burst && r_beat == flip_beat) rdata[5] = ~rdata[5];
        rresp = (ar_n - 1 == rresp_burst && r_beat == rresp_beat) ? 2'b11 : 2'b00;
        rlast = (r_beat == BL - 1);
      end
      r_hs = rvalid && rready;
      if (r_hs) begin
        r_n++; r_beat++;
        if (r_beat == BL) r_act = 0;
      end

      if (prev_awv && !prev_aw_hs && (awvalid !== 1'b1 || awaddr !== prev_awaddr)) stab_err++;
      awready = rnd_mode ? ($urandom_range(0, 3) == 0) : 1'b1;
      prev_awv = awvalid; prev_awaddr = awaddr; prev_aw_hs = awvalid && awready;
      if (awvalid && awready) begin
        if (exp_q.size() == 0 || awaddr !== exp_q[0] || awlen !== 8'd3 || awsize !== 3'd5 ||
            awburst !== 2'b01 || awid !== '0 || w_open || b_pend || aw_n >= NB) addr_err++;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        w_base = awaddr; w_beat = 0; w_open = 1; aw_n++;
      end

      if (prev_wv && !prev_w_hs && (wvalid !== 1'b1 || wdata !== prev_wdata || wlast !== prev_wlast)) stab_err++;
      wready = rnd_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
      prev_wv = wvalid; prev_wdata = wdata; prev_wlast = wlast; prev_w_hs = wvalid && wready;
      if (wvalid && wready) begin
        if (!w_open) order_err++;
        if (wdata !== m_beat(m_lfsr) || wstrb !== '1 || wlast !== (w_beat == BL - 1)) wdata_err++;
        mem[w_base + ADDR_W'(w_beat * BEAT_B)] = m_beat(m_lfsr);
        m_lfsr = m_step(m_lfsr);
        w_n++; w_beat++;
        if (w_beat == BL) begin w_open = 0; b_pend = 1; end
      end

      if (prev_arv && !prev_ar_hs && (arvalid !== 1'b1 || araddr !== prev_araddr)) stab_err++;
      arready = rnd_mode ? ($urandom_range(0, 3) == 0) : 1'b1;
      prev_arv = arvalid; prev_araddr = araddr; prev_ar_hs = arvalid && arready;
      if (arvalid && arready) begin
        if (exp_q.size() == 0 || araddr !== exp_q[0] || arlen !== 8'd3 || arsize !== 3'd5 ||
            arburst !== 2'b01 || arid !== '0 || r_act || b_n != NB) addr_err++;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        r_base = araddr; r_beat = 0; r_act = 1; ar_n++;
      end
    end
  end

  task automatic start_run();
    exp_q.delete();
    for (int n = 0; n < NB; n++) exp_q.push_back(burst_addr(n));
    for (int n = 0; n < NB; n++) exp_q.push_back(burst_addr(n));
    m_lfsr = SEED;
    aw_n = 0; w_n = 0; b_n = 0; ar_n = 0; r_n = 0;
    stab_err = 0; wdata_err = 0; order_err = 0; addr_err = 0;
    @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 5000 && done !== 1'b1; i++) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1; start = 0;
    repeat (3) @(negedge clk);
    reset = 0;
    @(negedge clk);
    tests_run++;
    if ({awvalid, wvalid, bready, arvalid, rready} !== 5'b0) begin
      tests_failed++; $display("FAIL reset_handshakes got %b want 00000", {awvalid, wvalid, bready, arvalid, rready});
    end
    tests_run++;
    if ({busy, done, pass, fail} !== 4'b0) begin
      tests_failed++; $display("FAIL reset_status got %b want 0000", {busy, done, pass, fail});
    end
    tests_run++;
    if (err_count !== 32'd0 || first_err_addr !== '0) begin
      tests_failed++; $display("FAIL reset_errors got %0d/%h want 0/0", err_count, first_err_addr);
    end
    tests_run++;
    if (dbg_state !== ST_IDLE) begin
      tests_failed++; $display("FAIL reset_state got %0d want %0d", dbg_state, ST_IDLE);
    end
  endtask

  task automatic test_ideal();
    rnd_mode = 0;
    start_run();
    wait_done();
    tests_run++;
    if ({done, pass, fail, busy} !== 4'b1100) begin
      tests_failed++; $display("FAIL ideal_status got %b want 1100", {done, pass, fail, busy});
    end
    tests_run++;
    if (err_count !== 32'd0) begin
      tests_failed++; $display("FAIL ideal_err_count got %0d want 0", err_count);
    end
    tests_run++;
    if (aw_n != NB || w_n != NB * BL || b_n != NB || ar_n != NB || r_n != NB * BL) begin
      tests_failed++; $display("FAIL ideal_counts got aw%0d w%0d b%0d ar%0d r%0d want 8/32/8/8/32", aw_n, w_n, b_n, ar_n, r_n);
    end
    tests_run++;
    if (wdata_err + addr_err + order_err != 0 || exp_q.size() != 0) begin
      tests_failed++; $display("FAIL ideal_payload got wdata%0d addr%0d order%0d left%0d want 0", wdata_err, addr_err, order_err, exp_q.size());
    end
  endtask

  task automatic test_backpressure();
    rnd_mode = 1;
    start_run();
    repeat (30) @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    wait_done();
    tests_run++;
    if ({done, pass, fail} !== 3'b110 || err_count !== 32'd0) begin
      tests_failed++; $display("FAIL bp_status got %b err %0d want 110 err 0", {done, pass, fail}, err_count);
    end
    tests_run++;
    if (aw_n != NB || w_n != NB * BL || b_n != NB || ar_n != NB || r_n != NB * BL) begin
      tests_failed++; $display("FAIL bp_counts got aw%0d w%0d b%0d ar%0d r%0d want 8/32/8/8/32", aw_n, w_n, b_n, ar_n, r_n);
    end
    tests_run++;
    if (stab_err != 0) begin
      tests_failed++; $display("FAIL bp_stability got %0d violations want 0", stab_err);
    end
    tests_run++;
    if (wdata_err + addr_err + order_err != 0 || exp_q.size() != 0) begin
      tests_failed++; $display("FAIL bp_payload got wdata%0d addr%0d order%0d left%0d want 0", wdata_err, addr_err, order_err, exp_q.size());
    end
  endtask

  task automatic test_data_flip();
    logic [ADDR_W-1:0] exp_first;
    rnd_mode = 1;
    flip_burst = 3; flip_beat = 2;
    exp_first = BASE + ADDR_W'(3 * 128 + 2 * 32);
    start_run();
    wait_done();
    flip_burst = -1; flip_beat = -1;
    tests_run++;
    if ({done, pass, fail} !== 3'b101) begin
      tests_failed++; $display("FAIL flip_status got %b want 101", {done, pass, fail});
    end
    tests_run++;
    if (err_count !== 32'd1) begin
      tests_failed++; $display("FAIL flip_err_count got %0d want 1", err_count);
    end
    tests_run++;
    if (first_err_addr !== exp_first) begin
      tests_failed++; $display("FAIL flip_first_addr got %h want %h", first_err_addr, exp_first);
    end
  endtask

  task automatic test_bad_resp();
    rnd_mode = 1;
    bresp_burst = 0;
    rresp_burst = $urandom_range(0, NB - 1);
    rresp_beat  = $urandom_range(0, BL - 1);
    start_run();
    wait_done();
    bresp_burst = -1; rresp_burst = -1; rresp_beat = -1;
    tests_run++;
    if ({done, pass, fail} !== 3'b101) begin
      tests_failed++; $display("FAIL resp_status got %b want 101", {done, pass, fail});
    end
    tests_run++;
    if (err_count !== 32'd2) begin
      tests_failed++; $display("FAIL resp_err_count got %0d want 2", err_count);
    end
    tests_run++;
    if (first_err_addr !== BASE) begin
      tests_failed++; $display("FAIL resp_first_addr got %h want %h", first_err_addr, BASE);
    end
  endtask

  task automatic test_reset_mid();
    rnd_mode = 0;
    start_run();
    for (int i = 0; i < 200 && !(w_n >= 2 && wvalid === 1'b1 && dbg_state == ST_W); i++) @(negedge clk);
    tests_run++;
    if (wvalid !== 1'b1) begin
      tests_failed++; $display("FAIL midreset_reach_w got wvalid=%b want 1", wvalid);
    end
    reset = 1;
    @(posedge clk);
    #1;
    tests_run++;
    if ({awvalid, wvalid, bready, arvalid, rready, busy, done, pass, fail} !== 9'b0 ||
        err_count !== 32'd0 || first_err_addr !== '0) begin
      tests_failed++; $display("FAIL midreset_outputs got %b err %0d first %h want all zero",
        {awvalid, wvalid, bready, arvalid, rready, busy, done, pass, fail}, err_count, first_err_addr);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 0;
    rnd_mode = 1;
    start_run();
    wait_done();
    tests_run++;
    if ({done, pass, fail} !== 3'b110 || err_count !== 32'd0) begin
      tests_failed++; $display("FAIL midreset_rerun got %b err %0d want 110 err 0", {done, pass, fail}, err_count);
    end
    tests_run++;
    if (w_n != NB * BL || r_n != NB * BL || wdata_err + addr_err + order_err + stab_err != 0) begin
      tests_failed++; $display("FAIL midreset_payload got w%0d r%0d errs %0d want 32/32/0", w_n, r_n,
        wdata_err + addr_err + order_err + stab_err);
    end
  endtask

  initial begin
    test_reset();
    test_ideal();
    test_backpressure();
    test_data_flip();
    test_bad_resp();
    test_ideal();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/emif_axi_traffic_gen.md
Name: emif_axi_traffic_gen

Overview:
- AXI4 initiator that exercises the LPDDR4 EMIF user port (the responder side) on the example-design top.
- Writes NUM_BURSTS INCR bursts of LFSR-derived data from BASE_ADDR, then reads them back and compares every beat.
- Reports done/pass/fail plus error count and the first failing address; runs in the EMIF user clock domain.
- Used for board bring-up and regression.

Parameters:
- ADDR_W, 33, AXI address width in bits.
- DATA_W, 256, AXI data width in bits; multiple of 32.
- ID_W, 7, AXI ID width in bits; all transactions use ID 0.
- BURST_LEN, 4, beats per burst (1..16). AxLEN = BURST_LEN-1.
- NUM_BURSTS, 1024, bursts per phase (≥1).
- BASE_ADDR, 0, start byte address; aligned to DATA_W/8*BURST_LEN.
- SEED, 32'h1234_5678, nonzero LFSR seed.

Ports:
- clk_clk  in  1  EMIF user clock.
- reset_reset  in  1  synchronous, active-high.
- start  in  1  pulse: begin a run when idle or done.
- awaddr/awlen/awsize/awburst/awid/awvalid  out  ADDR_W/8/3/2/ID_W/1  AXI write address channel.
- awready  in  1.
- wdata/wstrb/wlast/wvalid  out  DATA_W/DATA_W/8/1/1  AXI write data channel.
- wready  in  1.
- bresp/bvalid  in  2/1; bready  out  1.
- araddr/arlen/arsize/arburst/arid/arvalid  out  ADDR_W/8/3/2/ID_W/1  AXI read address channel.
- arready  in  1.
- rdata/rresp/rlast/rvalid  in  DATA_W/2/1/1; rready  out  1.
- busy/done/pass/fail  out  1 each  status.
- err_count  out  32  count of mismatched beats plus bad responses; saturates at all-ones.
- first_err_addr  out  ADDR_W  byte address of the first failing beat.

Behaviour:
- Reset: all valids, bready, rready, busy, done, pass, fail = 0; err_count = 0; first_err_addr = 0; FSM = IDLE.
- FSM states: IDLE, AW, W, B, AR, R, DONE.
  - IDLE/DONE --start--> AW. On entry: LFSR = SEED, burst counter = 0, err_count cleared, first_err_addr cleared, done/pass/fail cleared.
  - AW: awvalid=1 until awready is sampled high → W.
  - W: wvalid=1; beat advances on wvalid&wready; wlast on beat BURST_LEN-1; last beat accepted → B.
  - B: bready=1; on bvalid, next burst → AW, or after NUM_BURSTS → AR with LFSR reseeded to SEED and counter cleared.
  - AR: arvalid=1 until arready → R.
  - R: rready=1; each rvalid beat is compared; rlast → AR or, after final burst → DONE.
  - DONE: done=1, pass=(err_count==0), fail=!pass, busy=0.
  - busy=1 in AW through R.
- Payload valid/address fields stay stable while valid is high and ready is low. No W before AW completes. One outstanding transaction at a time.
- Addressing: burst n address = BASE_ADDR + n*BURST_LEN*DATA_W/8, computed modulo 2^ADDR_W (wraps silently). awsize/arsize = log2(DATA_W/8); burst type INCR (2'b01); wstrb all ones.
- Data pattern: 32-bit Galois LFSR, polynomial x^32+x^22+x^2+x+1, advances once per accepted W beat or R beat. Word i of the beat = lfsr ^ (i*32'h9E37_79B9). Read expected data regenerates identically.
- Errors, each adding 1 to err_count:
  - rdata mismatch, or rresp≠OKAY (per beat, counted once even if both).
  - bresp≠OKAY (per burst).
  - rlast on a beat other than BURST_LEN-1: the bench flags this; the design counts 1 error and ends the burst.
- first_err_addr latches on the first error: the beat's byte address, or the burst address for bresp errors.
- start while busy is ignored. Reset mid-transaction drops valids immediately; the interconnect is reset by the same reset.

Decomposition:
- Package emif_tg_pkg: FSM state enum, AXI resp/burst constants (OKAY, INCR), LFSR polynomial, golden-ratio constant, beat-pattern function.
- Sub-module emif_tg_lfsr: seed load, advance enable, DATA_W pattern expansion.
- Two instances: write generator and read checker.

Test Plan:
- Ideal responder (always-ready, zero-latency memory), NUM_BURSTS=8, BURST_LEN=4: pulse start → 32 W beats, 32 R beats, done=1, pass=1, err_count=0.
- Responder with random backpressure on awready/wready/arready/rvalid → all AXI payloads stable while stalled; pass=1; beat counts identical.
- Flip bit 5 of rdata on read beat 2 of burst 3 (DATA_W=256) → err_count=1, first_err_addr=BASE+3*128+2*32, fail=1.
- bresp=SLVERR on burst 0 plus rresp=DECERR on one beat → err_count=2, first_err_addr=BASE_ADDR.
- Reset asserted in W state on beat 2 → next cycle all outputs at reset values; a new start gives a clean pass.
- BASE_ADDR at 2^ADDR_W-256 with 4 bursts → addresses wrap to 0, 128; pass=1.
